// File: rtl/arb_pkg.sv
// Shared types, widths and the rotating priority search for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } search_t;

    // First set bit of req at or after ptr, ascending, wrapping 7 -> 0.
    function automatic search_t rr_search(input logic [N_REQ-1:0] req,
                                          input logic [IDX_W-1:0] ptr);
        search_t          res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_3bit_ref.sv
// 3-to-8 one-hot decoder used to build the grant vector from the binary grant index.
module decoder_3bit_ref (
    input  logic [2:0] in,
    output logic [7:0] out
);

    always_comb begin
        out = 8'b0000_0001 << in;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a rotating priority pointer and a hold-limit
// counter that forces rotation; every output comes straight from registers.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    // HOLD_MAX of 0 disables forced rotation; the counter then just saturates at 255.
    localparam logic       HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'hFF : 8'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    logic [N_REQ-1:0] gnt_raw;
    logic [N_REQ-1:0] search_req;
    search_t          sel;
    logic             rel_user;
    logic             hold_hit;

    decoder_3bit_ref u_dec (
        .in  (gnt_id_q),
        .out (gnt_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    // While granting, the current holder is masked out so it cannot win its own release.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        preempt_d  = 1'b0;
        search_req = (state_q == GRANT) ? (req & ~gnt_raw) : req;
        sel        = rr_search(search_req, ptr_q);
        rel_user   = done || !req[gnt_id_q];
        hold_hit   = HOLD_EN && (cnt_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                if (sel.found) begin
                    state_d  = GRANT;
                    gnt_id_d = sel.idx;
                    ptr_d    = sel.idx + IDX_W'(1);
                    cnt_d    = '0;
                end
            end
            GRANT: begin
                if (rel_user || hold_hit) begin
                    preempt_d = hold_hit && !rel_user;
                    if (sel.found) begin
                        gnt_id_d = sel.idx;
                        ptr_d    = sel.idx + IDX_W'(1);
                        cnt_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_id    = gnt_id_q;
    assign gnt       = gnt_raw & {N_REQ{gnt_valid}};
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: one instance at the default hold limit, one at HOLD_MAX=4,
// both fed the same inputs and checked against hand-computed grant sequences.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic [7:0] gnt16, gnt4;
    logic [2:0] gnt_id16, gnt_id4;
    logic       gnt_valid16, gnt_valid4;
    logic       preempt16, preempt4;

    int tests_run;
    int tests_failed;

    rr_arbiter_8 #(.HOLD_MAX(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt16),
        .gnt_id    (gnt_id16),
        .gnt_valid (gnt_valid16),
        .preempt   (preempt16)
    );

    rr_arbiter_8 #(.HOLD_MAX(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt4),
        .gnt_id    (gnt_id4),
        .gnt_valid (gnt_valid4),
        .preempt   (preempt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({gnt16, gnt_id16, gnt_valid16, preempt16} !== 13'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset16: gnt=%b id=%0d valid=%b preempt=%b, want all 0",
                     gnt16, gnt_id16, gnt_valid16, preempt16);
        end
        tests_run++;
        if ({gnt4, gnt_id4, gnt_valid4, preempt4} !== 13'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset4: gnt=%b id=%0d valid=%b preempt=%b, want all 0",
                     gnt4, gnt_id4, gnt_valid4, preempt4);
        end
    endtask

    task automatic test_single_grant();
        apply_reset();
        done = 1'b1;
        step();
        tests_run++;
        if (gnt_valid16 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_done: valid=%b, want 0", gnt_valid16);
        end
        done = 1'b0;
        req  = 8'b0000_0100;
        step();
        tests_run++;
        if (gnt16 !== 8'b0000_0100 || gnt_id16 !== 3'd2 || gnt_valid16 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_grant: gnt=%b id=%0d valid=%b, want 00000100 2 1",
                     gnt16, gnt_id16, gnt_valid16);
        end
        done = 1'b1;
        step();
        tests_run++;
        if (gnt16 !== 8'h00 || gnt_valid16 !== 1'b0 || gnt_id16 !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL single_release: gnt=%b valid=%b id=%0d, want 00000000 0 2",
                     gnt16, gnt_valid16, gnt_id16);
        end
        done = 1'b0;
        req  = 8'h00;
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_id;
        apply_reset();
        req = 8'hFF;
        step();
        tests_run++;
        if (gnt_id16 !== 3'd0 || gnt_valid16 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: id=%0d valid=%b, want 0 1", gnt_id16, gnt_valid16);
        end
        done = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_id = 3'(i);
            tests_run++;
            if (gnt_id16 !== exp_id || gnt_valid16 !== 1'b1 || gnt16 !== (8'd1 << exp_id)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_seq%0d: id=%0d valid=%b gnt=%b, want %0d 1 %b",
                         i, gnt_id16, gnt_valid16, gnt16, exp_id, 8'd1 << exp_id);
            end
        end
        done = 1'b0;
        req  = 8'h00;
        step();
    endtask

    task automatic test_hold_limit();
        logic [2:0] exp_id;
        logic       exp_pre;
        apply_reset();
        req = 8'b1000_0001;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_id  = (c <= 4) ? 3'd0 : ((c <= 8) ? 3'd7 : 3'd0);
            exp_pre = (c == 5) || (c == 9);
            tests_run++;
            if (gnt_id4 !== exp_id || preempt4 !== exp_pre || gnt_valid4 !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL hold4_c%0d: id=%0d preempt=%b valid=%b, want %0d %b 1",
                         c, gnt_id4, preempt4, gnt_valid4, exp_id, exp_pre);
            end
        end
        tests_run++;
        if (gnt_id16 !== 3'd0 || preempt16 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold16_keep: id=%0d preempt=%b, want 0 0", gnt_id16, preempt16);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_hold_with_done();
        apply_reset();
        req = 8'b1000_0001;
        for (int c = 1; c <= 4; c++) step();
        done = 1'b1;
        step();
        tests_run++;
        if (gnt_id4 !== 3'd7 || preempt4 !== 1'b0 || gnt_valid4 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold_done: id=%0d preempt=%b valid=%b, want 7 0 1",
                     gnt_id4, preempt4, gnt_valid4);
        end
        done = 1'b0;
        req  = 8'h00;
        step();
    endtask

    task automatic test_hold16_single();
        apply_reset();
        req = 8'b0001_0000;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (c == 5) begin
                tests_run++;
                if (gnt_valid4 !== 1'b0 || preempt4 !== 1'b1 || gnt_id4 !== 3'd4) begin
                    tests_failed++;
                    $display("[TB] FAIL hold4_idle: valid=%b preempt=%b id=%0d, want 0 1 4",
                             gnt_valid4, preempt4, gnt_id4);
                end
            end
            if (c == 16) begin
                tests_run++;
                if (gnt_valid16 !== 1'b1 || gnt_id16 !== 3'd4 || preempt16 !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL hold16_last: valid=%b id=%0d preempt=%b, want 1 4 0",
                             gnt_valid16, gnt_id16, preempt16);
                end
            end
            if (c == 17) begin
                tests_run++;
                if (gnt_valid16 !== 1'b0 || preempt16 !== 1'b1 || gnt16 !== 8'h00) begin
                    tests_failed++;
                    $display("[TB] FAIL hold16_expire: valid=%b preempt=%b gnt=%b, want 0 1 0",
                             gnt_valid16, preempt16, gnt16);
                end
            end
            if (c == 18) begin
                tests_run++;
                if (gnt_valid16 !== 1'b1 || gnt_id16 !== 3'd4 || preempt16 !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL hold16_regrant: valid=%b id=%0d preempt=%b, want 1 4 0",
                             gnt_valid16, gnt_id16, preempt16);
                end
            end
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_req_drop();
        apply_reset();
        req = 8'b0000_1000;
        step();
        req = 8'b0000_1010;
        step();
        tests_run++;
        if (gnt_id16 !== 3'd3 || gnt_valid16 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL drop_hold: id=%0d valid=%b, want 3 1", gnt_id16, gnt_valid16);
        end
        req = 8'b0000_0010;
        step();
        tests_run++;
        if (gnt_id16 !== 3'd1 || gnt16 !== 8'b0000_0010 || gnt_id4 !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL drop_wrap: id16=%0d gnt16=%b id4=%0d, want 1 00000010 1",
                     gnt_id16, gnt16, gnt_id4);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (gnt16 !== 8'h00 || gnt_valid16 !== 1'b0 || gnt_id16 !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: gnt=%b valid=%b id=%0d, want 0 0 0",
                     gnt16, gnt_valid16, gnt_id16);
        end
        req = 8'b1000_0010;
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (gnt_id16 !== 3'd1 || gnt_valid16 !== 1'b1 || gnt16 !== 8'b0000_0010) begin
            tests_failed++;
            $display("[TB] FAIL post_reset: id=%0d valid=%b gnt=%b, want 1 1 00000010",
                     gnt_id16, gnt_valid16, gnt16);
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req          = 8'h00;
        done         = 1'b0;
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_hold_limit();
        test_hold_with_done();
        test_hold16_single();
        test_req_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among 8 requesters. The arbiter holds a registered 3-bit grant index and drives the one-hot grant vector through the team's 3-to-8 one-hot decoder. Fairness comes from a rotating priority pointer. A hold-limit counter forces rotation when a requester keeps the grant too long. The block sits between the requesting engines and the shared resource mux, and its `gnt_id` output drives the mux select directly.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive grant cycles for one holder. 0 disables forced rotation. Legal range 0..255.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request vector; bit i belongs to requester i.
- `done`  in  1: the current holder releases the grant; sampled only while `gnt_valid`=1.
- `gnt`  out  8: one-hot grant; all zero when `gnt_valid`=0.
- `gnt_id`  out  3: binary index of the current holder.
- `gnt_valid`  out  1: a grant is active.
- `preempt`  out  1: one-cycle pulse when the hold limit revokes a grant.

## Operation
- FSM has two states:
  - IDLE: no grant.
  - GRANT: the holder is `gnt_id`.
- Search rule: pick the first set `req` bit starting at index `ptr`, ascending, wrapping 7 to 0. With `ptr`=5 the order is 5,6,7,0,1,2,3,4.
- IDLE behaviour:
  - If `req` is nonzero at the edge, move to GRANT.
  - Load `gnt_id` with the search result.
  - Set `ptr` to `gnt_id`+1 mod 8.
  - Clear `cnt`.
  - Otherwise stay in IDLE.
- GRANT release condition is met when any of these holds at the edge:
  - `done`=1
  - `req[gnt_id]`=0
  - `HOLD_MAX`≠0 and `cnt`=`HOLD_MAX`-1
- On release:
  - Search the requesters excluding the current holder, starting at `ptr` (already `gnt_id`+1).
  - If one is found: back-to-back grant (stay in GRANT, load the new `gnt_id`, update `ptr`, clear `cnt`).
  - If none is found: go to IDLE, set `gnt_valid` to 0, keep `gnt_id` unchanged.
  - The released holder cannot win again in the same cycle even if its `req` is still high. It is considered only from the next search.
- No release: `cnt` increments, saturating at `HOLD_MAX`-1.
- `preempt` is 1 for one cycle after the edge where release was caused only by the hold limit. If `done`=1 or `req[gnt_id]`=0 in the same cycle, `preempt` stays 0.
- `gnt` = decoder(`gnt_id`) ANDed with `gnt_valid`, replicated across 8 bits.
- Width rules:
  - `cnt` is 8 bits.
  - `ptr` and `gnt_id` are 3 bits and wrap naturally modulo 8.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `preempt`=0, `ptr`=0, `cnt`=0, state IDLE.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge. The first grant after reset is searched from index 0.
- Latency:
  - `req` seen at edge k in IDLE gives `gnt_valid`=1 after edge k.
  - A release at edge k gives the next holder after edge k, so there is no bubble cycle.
- All outputs are registered or derived from registers only. There is no combinational path from `req` or `done` to any output.
- With `HOLD_MAX`=N, a continuously requesting holder keeps the grant for exactly N cycles.
- `done` or `req` changes while `gnt_valid`=0, other than `req` starting a new grant, have no effect.

## Structure
- Shared package `arb_pkg` holds:
  - `N_REQ`=8 and `IDX_W`=3
  - state enum {IDLE, GRANT}
  - the wrap-around search function (rotating priority encoder)
- One sub-module: `decoder_3bit_ref` (3-to-8 one-hot decoder; `in`=`gnt_id`, `out`=raw one-hot).
- The top level contains the FSM, `ptr`, `cnt`, and the output gating.

## Test plan
- Reset, then `req`=8'b0000_0100 → after one edge `gnt`=8'b0000_0100, `gnt_id`=2, `gnt_valid`=1; then `done`=1 with no other requests → `gnt_valid`=0 and `gnt`=0 after the next edge.
- `req`=8'hFF held, `done` pulsed every cycle → `gnt_id` sequence 0,1,2,…,7,0 with no idle cycles and `gnt_valid` constantly 1.
- `HOLD_MAX`=4, `req`=8'b1000_0001, no `done`:
  - `gnt_id`=0 for 4 cycles.
  - `preempt` pulses once.
  - `gnt_id`=7 for 4 cycles, then 0 again.
- `HOLD_MAX`=4 with `done`=1 on the 4th cycle → rotation occurs and `preempt` stays 0.
- Holder 3 drops `req[3]` mid-grant while `req[1]`=1 → next edge `gnt_id`=1 (wrap search 4..7,0,1).
- Assert `rst_n`=0 mid-grant, between clock edges → `gnt`, `gnt_valid`, and `gnt_id` are 0 immediately. After release of reset with `req`=8'b1000_0010 → `gnt_id`=1 (`ptr` was reset to 0).
